mux_arb_pipe: RTL
=================

Name: mux_arb_pipe

Overview:
- Parametrised successor to the combinational 2:1 32-bit datapath mux.
- Selects one of NUM_CH WIDTH-bit channels and holds the result in a one-entry output register.
- Each input channel and the output use a valid/ready handshake.
- Channel selection is either fixed (runtime `sel`) or round-robin. Sits between MIPS pipeline stages wherever several producers share one consumer.

Parameters:
- WIDTH, 32, data width per channel (>=1)
- NUM_CH, 4, number of input channels (>=2)
- SEL_W, $clog2(NUM_CH), width of sel/out_ch (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_CH  per-channel request
- in_data  in  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  out  NUM_CH  per-channel accept (one-hot or zero)
- rr_en  in  1  1 = round-robin, 0 = fixed select
- sel  in  SEL_W  channel index used when rr_en=0
- out_valid  out  1  output register holds a beat
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  registered selected data
- out_ch  out  SEL_W  index of channel that produced out_data

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- load_en = !out_valid || out_ready. Throughput is 1 beat/cycle when the consumer is always ready.
- Grant is combinational from the current inputs:
  - rr_en=0: grant=onehot(sel) if sel<NUM_CH and in_valid[sel], else 0. sel>=NUM_CH grants nothing and never errors.
  - rr_en=1: first valid channel searching last+1, last+2, …, wrapping modulo NUM_CH. The channel at `last` is checked last.
- in_ready[i] = grant[i] && load_en. Zero-or-one-hot every cycle.
  - in_ready does not depend on in_valid[i] of other channels except through the arbitration.
- Transfer on channel i when in_valid[i] && in_ready[i]. At that posedge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - If rr_en=1, last <= i.
- Fixed-mode grants do not update last.
- If load_en=1 and there is no grant: out_valid <= 0; out_data and out_ch hold their old values.
- Stall: while out_valid && !out_ready, out_data and out_ch are stable and all in_ready=0.
- Latency: accepted input appears on the output the next cycle.
- Simultaneous out_ready and a new grant: the old beat is consumed and the new beat is loaded in the same edge, with no bubble.
- Changing rr_en or sel mid-stall does not affect the held beat; the change applies from the next load.
- Reset mid-transfer: the held beat is dropped and the pointer returns to NUM_CH-1.
- Inputs are not required to hold in_valid until accepted. Dropping it is legal and simply yields no grant.

Decomposition:
- Package mux_pkg:
  - default WIDTH/NUM_CH constants
  - a function for ceil-log2 with a minimum of 1
  - a MODE_FIXED/MODE_RR encoding for rr_en
- Sub-module rr_arbiter:
  - Parameter NUM_CH.
  - Inputs req, last, en. Output one-hot gnt. Purely combinational rotate-priority search.
  - The top level owns the pointer register and the output register.

Test Plan:
1. Reset → hold rr_en=0, sel=1, in_valid=4'b0010, ch1=40, out_ready=1; release rst_n → in_ready=4'b0010 in the first active cycle; out_data=40, out_ch=1, out_valid=1 one cycle later.
2. Round-robin fairness → rr_en=1, in_valid=4'b1111 constant, data chN=N+100, out_ready=1 → out_ch sequence 0,1,2,3,0,1; out_data=100,101,102,103,100; out_valid stays 1 with no bubbles.
3. Back-pressure → out_ready=0 for 3 cycles after a beat with value 0xDEADBEEF is loaded → out_data remains 0xDEADBEEF, in_ready=0 throughout; raise out_ready → next beat loads on that same edge.
4. Wrap and skip → rr_en=1, last=2, in_valid=4'b0011 → grant ch0, then ch1, then ch0.
5. Out-of-range or idle select → rr_en=0, sel=3 with NUM_CH=3 override, all valid → in_ready=0; the pending beat drains and out_valid falls to 0.
6. Reset mid-stall → out_valid=1, out_ready=0, assert rst_n=0 asynchronously mid-cycle → out_valid=0, out_data=0 immediately; after release, rr_en=1 with all valid grants ch0 first.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the multi-channel arbitrated output mux.
//   DEFAULT_WIDTH / DEFAULT_NUM_CH : default data width and channel count
//   clog2_min1                     : ceil-log2 that never returns less than 1
//   mode_e                         : encoding of the rr_en pin
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_NUM_CH = 4;

    // A 2-channel mux still needs a 1-bit select, so clamp at 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req  : per-channel requests
//   last : index of the most recently granted channel; search starts at last+1
//   en   : when low no grant is produced
//   gnt  : one-hot (or zero) grant
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Walk last+1 .. last+NUM_CH (mod NUM_CH); the channel at last comes last.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = SEL_W'((32'(last) + k) % NUM_CH);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_pipe.sv
// NUM_CH-to-1 arbitrated mux with a one-entry registered output stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : per-channel handshake, in_ready is one-hot or zero
//   in_data             : channel i at bits [i*WIDTH +: WIDTH]
//   rr_en, sel          : round-robin enable, fixed channel index when rr_en=0
//   out_valid/out_ready : output handshake
//   out_data, out_ch    : registered beat and the channel it came from
module mux_arb_pipe
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    rr_en,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch
);

    mode_e             mode;
    logic              load_en;
    logic              xfer;
    logic [NUM_CH-1:0] rr_gnt;
    logic [NUM_CH-1:0] fix_gnt;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  gnt_data;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  last_q,      last_d;

    assign mode    = mode_e'(rr_en);
    assign load_en = !out_valid_q || out_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req  (in_valid),
        .last (last_q),
        .en   (mode == MODE_RR),
        .gnt  (rr_gnt)
    );

    // Compare against every legal index so an out-of-range sel simply matches nothing.
    always_comb begin
        fix_gnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(sel) == i && in_valid[i]) begin
                fix_gnt[i] = 1'b1;
            end
        end
    end

    assign gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    assign in_ready = gnt & {NUM_CH{load_en}};
    // Grants only ever go to valid channels, so any ready is a transfer.
    assign xfer     = |in_ready;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt_idx;
            end
        end
        if (xfer && mode == MODE_RR) begin
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
